// File: rtl/runway_pkg.sv
// Shared types and helpers for the runway light sequencer.
package runway_pkg;

  typedef enum logic [1:0] {
    CALM       = 2'b00,
    SWEEP_DOWN = 2'b01,
    SWEEP_UP   = 2'b10,
    FLASH      = 2'b11
  } mode_t;

  // Lamp patterns are built in a 32-bit container and sliced by the user.
  function automatic logic [31:0] even_mask(input int n);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < n && (i % 2) == 0) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [31:0] odd_mask(input int n);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < n && (i % 2) == 1) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic is_onehot(input logic [31:0] v);
    return $onehot(v);
  endfunction

endpackage

// File: rtl/runway_lights_seq_rate_tick.sv
// Programmable step-rate divider: tick is high on the edge that should
// advance the pattern, i.e. once every rate+1 un-held cycles.
module rate_tick
  import runway_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] rate,
  input  logic             hold,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Compare with >= so lowering rate below the current count fires at once;
  // hold freezes everything, even with rate=0.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (!hold) begin
      if (cnt_q >= rate) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/runway_lights_seq.sv
// Runway / wind-indicator light sequencer. The wind inputs select one of
// four display modes; the pattern advances at the programmed rate.
module runway_lights_seq
  import runway_pkg::*;
#(
  parameter int N_LIGHTS = 3,
  parameter int DIV_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                w1,
  input  logic                w0,
  input  logic [DIV_W-1:0]    rate,
  input  logic                hold,
  output logic [N_LIGHTS-1:0] lights,
  output logic                step,
  output logic [1:0]          mode_o
);

  localparam logic [31:0]         EVEN_W   = even_mask(N_LIGHTS);
  localparam logic [31:0]         ODD_W    = odd_mask(N_LIGHTS);
  localparam logic [N_LIGHTS-1:0] EVEN     = EVEN_W[N_LIGHTS-1:0];
  localparam logic [N_LIGHTS-1:0] ODD      = ODD_W[N_LIGHTS-1:0];
  localparam logic [N_LIGHTS-1:0] ALL_ON   = '1;
  localparam logic [N_LIGHTS-1:0] MSB_ONLY = {1'b1, {(N_LIGHTS-1){1'b0}}};
  localparam logic [N_LIGHTS-1:0] LSB_ONLY = {{(N_LIGHTS-1){1'b0}}, 1'b1};

  logic [N_LIGHTS-1:0] lights_q;
  logic [N_LIGHTS-1:0] lights_d;
  logic                step_q;
  mode_t               mode_q;
  mode_t               mode_sel;
  logic                advance;
  logic                onehot;

  rate_tick #(.DIV_W(DIV_W)) u_rate_tick (
    .clk   (clk),
    .reset (reset),
    .rate  (rate),
    .hold  (hold),
    .tick  (advance)
  );

  assign mode_sel = mode_t'({w1, w0});
  assign onehot   = is_onehot(32'(lights_q));

  // Next pattern: each mode has an entry rule for patterns it does not
  // recognise, so a mode change takes effect directly with no blank cycle.
  always_comb begin
    lights_d = lights_q;
    case (mode_sel)
      CALM:       lights_d = (lights_q == EVEN) ? ODD : EVEN;
      SWEEP_DOWN: lights_d = onehot ? {lights_q[0], lights_q[N_LIGHTS-1:1]} : MSB_ONLY;
      SWEEP_UP:   lights_d = onehot ? {lights_q[N_LIGHTS-2:0], lights_q[N_LIGHTS-1]} : LSB_ONLY;
      FLASH:      lights_d = (lights_q == ALL_ON) ? '0 : ALL_ON;
      default:    lights_d = EVEN;
    endcase
  end

  // Pattern, step strobe and applied-mode registers; mode is sampled only
  // on the advancing edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      lights_q <= EVEN;
      step_q   <= 1'b0;
      mode_q   <= CALM;
    end else begin
      step_q <= advance;
      if (advance) begin
        lights_q <= lights_d;
        mode_q   <= mode_sel;
      end
    end
  end

  assign lights = lights_q;
  assign step   = step_q;
  assign mode_o = mode_q;

endmodule
